fpnew_noncomp_sched: RTL and testbench

FPNEW_NONCOMP_SCHED -- requirements
Module: fpnew_noncomp_sched

---
 rtl/fpnew_noncomp_sched.sv | 162 ++++++++++++++++
 tb/tb_fpnew_noncomp_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_noncomp_sched.sv
// Round-robin scheduler sharing one combinational FP non-computational unit among NumReq
// requesters, with a single registered output slot and a saturating invalid-op counter.
module fpnew_noncomp_sched #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned Width  = 32,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned OpW   = 4,
  localparam int unsigned RmW   = 3,
  localparam int unsigned StatW = 5,
  localparam int unsigned ClsW  = 10
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  // Requester side
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][1:0][Width-1:0]    req_operands_i,
  input  logic [NumReq-1:0][1:0]               req_is_boxed_i,
  input  logic [NumReq-1:0][OpW-1:0]           req_op_i,
  input  logic [NumReq-1:0][RmW-1:0]           req_rnd_mode_i,
  input  logic [NumReq-1:0]                    req_op_mod_i,
  // Shared unit side
  output logic [1:0][Width-1:0]                unit_operands_o,
  output logic [1:0]                           unit_is_boxed_o,
  output logic [OpW-1:0]                       unit_op_o,
  output logic [RmW-1:0]                       unit_rnd_mode_o,
  output logic                                 unit_op_mod_o,
  input  logic [Width-1:0]                     unit_result_i,
  input  logic [StatW-1:0]                     unit_status_i,
  input  logic                                 unit_ext_bit_i,
  input  logic [ClsW-1:0]                      unit_class_mask_i,
  input  logic                                 unit_is_class_i,
  // Result side
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [IdxW-1:0]                      out_id_o,
  output logic [Width-1:0]                     out_result_o,
  output logic [StatW-1:0]                     out_status_o,
  output logic                                 out_ext_bit_o,
  output logic [ClsW-1:0]                      out_class_mask_o,
  output logic                                 out_is_class_o,
  output logic [15:0]                          nv_count_o,
  output logic                                 busy_o
);

  localparam logic [ClsW-1:0] ClassQnan = 10'h200;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NumReq - 1);

  logic [IdxW-1:0]  rr_q, rr_d;
  logic [IdxW-1:0]  grant_idx, cand_idx, sel_idx;
  logic             any_valid, slot_free, issue, handshake;

  logic             out_valid_q, out_valid_d;
  logic [IdxW-1:0]  out_id_q;
  logic [Width-1:0] out_result_q;
  logic [StatW-1:0] out_status_q;
  logic             out_ext_bit_q;
  logic [ClsW-1:0]  out_class_mask_q;
  logic             out_is_class_q;
  logic [15:0]      nv_count_q, nv_count_d;

  // First valid requester at or above rr_q, wrapping modulo NumReq.
  always_comb begin
    any_valid = 1'b0;
    grant_idx = rr_q;
    cand_idx  = rr_q;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand_idx = IdxW'((32'(rr_q) + k) % NumReq);
      if (!any_valid && req_valid_i[cand_idx]) begin
        any_valid = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign slot_free = ~out_valid_q | out_ready_i;
  assign issue     = slot_free & ~flush_i & any_valid & ~rst_i;
  assign handshake = out_valid_q & out_ready_i & ~flush_i;

  always_comb begin
    req_ready_o = '0;
    if (issue) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // With nothing requesting, the unit still sees the requester at the round-robin pointer.
  assign sel_idx         = any_valid ? grant_idx : rr_q;
  assign unit_operands_o = req_operands_i[sel_idx];
  assign unit_is_boxed_o = req_is_boxed_i[sel_idx];
  assign unit_op_o       = req_op_i[sel_idx];
  assign unit_rnd_mode_o = req_rnd_mode_i[sel_idx];
  assign unit_op_mod_o   = req_op_mod_i[sel_idx];

  always_comb begin
    rr_d = rr_q;
    if (issue) begin
      rr_d = (grant_idx == LastIdx) ? '0 : grant_idx + IdxW'(1);
    end
  end

  // Flush wins over both a new issue and a pending drain.
  always_comb begin
    out_valid_d = out_valid_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (issue) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    nv_count_d = nv_count_q;
    if (handshake && out_status_q[StatW-1] && (nv_count_q != 16'hFFFF)) begin
      nv_count_d = nv_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      nv_count_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      nv_count_q  <= nv_count_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_id_q         <= '0;
      out_result_q     <= '0;
      out_status_q     <= '0;
      out_ext_bit_q    <= 1'b0;
      out_class_mask_q <= ClassQnan;
      out_is_class_q   <= 1'b0;
    end else if (issue) begin
      out_id_q         <= grant_idx;
      out_result_q     <= unit_result_i;
      out_status_q     <= unit_status_i;
      out_ext_bit_q    <= unit_ext_bit_i;
      out_class_mask_q <= unit_class_mask_i;
      out_is_class_q   <= unit_is_class_i;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign busy_o           = out_valid_q;
  assign out_id_o         = out_id_q;
  assign out_result_o     = out_result_q;
  assign out_status_o     = out_status_q;
  assign out_ext_bit_o    = out_ext_bit_q;
  assign out_class_mask_o = out_class_mask_q;
  assign out_is_class_o   = out_is_class_q;
  assign nv_count_o       = nv_count_q;

endmodule

// File: tb/tb_fpnew_noncomp_sched.sv
// Bench for fpnew_noncomp_sched: toy FP unit attached, directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_fpnew_noncomp_sched;
  localparam int N = 2;
  localparam int W = 32;
  localparam logic [3:0] OpSgnj = 4'd6, OpMinmax = 4'd7, OpCmp = 4'd8, OpClass = 4'd9;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  st;
    logic        ext;
    logic [9:0]  cls;
    logic        iscls;
  } ures_t;

  logic clk, rst, flush, out_ready;
  logic [N-1:0] req_valid, req_ready;
  logic [N-1:0][1:0][W-1:0] req_operands;
  logic [N-1:0][1:0] req_boxed;
  logic [N-1:0][3:0] req_op;
  logic [N-1:0][2:0] req_rnd;
  logic [N-1:0] req_mod;
  logic [1:0][W-1:0] unit_operands;
  logic [1:0] unit_boxed;
  logic [3:0] unit_op;
  logic [2:0] unit_rnd;
  logic unit_mod;
  ures_t u;
  logic out_valid, out_ext, out_iscls, busy;
  logic [0:0] out_id;
  logic [W-1:0] out_result;
  logic [4:0] out_status;
  logic [9:0] out_cls;
  logic [15:0] nv_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int    m_rr, m_id, m_nv;
  logic  m_valid;
  ures_t m_out;

  fpnew_noncomp_sched #(.NumReq(N), .Width(W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_operands_i(req_operands),
    .req_is_boxed_i(req_boxed), .req_op_i(req_op), .req_rnd_mode_i(req_rnd),
    .req_op_mod_i(req_mod),
    .unit_operands_o(unit_operands), .unit_is_boxed_o(unit_boxed), .unit_op_o(unit_op),
    .unit_rnd_mode_o(unit_rnd), .unit_op_mod_o(unit_mod),
    .unit_result_i(u.res), .unit_status_i(u.st), .unit_ext_bit_i(u.ext),
    .unit_class_mask_i(u.cls), .unit_is_class_i(u.iscls),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_id_o(out_id),
    .out_result_o(out_result), .out_status_o(out_status), .out_ext_bit_o(out_ext),
    .out_class_mask_o(out_cls), .out_is_class_o(out_iscls),
    .nv_count_o(nv_count), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy unit: real min/max on ordinary numbers, otherwise a mix of every input field.
  function automatic ures_t unit_fn(input logic [31:0] a, input logic [31:0] b,
                                    input logic [1:0] boxed, input logic [3:0] op,
                                    input logic [2:0] rnd, input logic mod);
    ures_t r;
    logic lt;
    r.st    = '0;
    r.ext   = b[0] ^ mod ^ boxed[0] ^ boxed[1];
    r.cls   = 10'd1 << (a[3:0] % 4'd10);
    r.iscls = (op == OpClass);
    if (a[31] != b[31]) lt = a[31];
    else if (a[31]) lt = a[30:0] > b[30:0];
    else lt = a[30:0] < b[30:0];
    case (op)
      OpMinmax: r.res = ((rnd == 3'd0) == lt) ? a : b;
      OpCmp: begin
        r.res = {31'd0, a == b};
        r.st  = {a[0], 4'd0};
      end
      default: begin
        r.res = a ^ {b[15:0], b[31:16]} ^ {25'd0, rnd, op};
        r.st  = {4'd0, mod};
      end
    endcase
    return r;
  endfunction

  always_comb u = unit_fn(unit_operands[0], unit_operands[1], unit_boxed, unit_op, unit_rnd,
                          unit_mod);

  function automatic int grant_of();
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic m_issue();
    return (!m_valid || out_ready) && !flush && !rst && (grant_of() >= 0);
  endfunction

  function automatic logic [N-1:0] exp_ready();
    if (m_issue()) return N'(1) << grant_of();
    return '0;
  endfunction

  task automatic model_reset();
    m_rr = 0; m_id = 0; m_nv = 0; m_valid = 1'b0;
    m_out = '{res: '0, st: '0, ext: 1'b0, cls: 10'h200, iscls: 1'b0};
  endtask

  task automatic model_update();
    int g;
    logic iss, hs;
    g   = grant_of();
    iss = m_issue();
    hs  = m_valid && out_ready && !flush;
    if (hs && m_out.st[4] && m_nv < 65535) m_nv++;
    if (flush) m_valid = 1'b0;
    else if (iss) begin
      m_valid = 1'b1;
      m_id    = g;
      m_out   = unit_fn(req_operands[g][0], req_operands[g][1], req_boxed[g], req_op[g],
                        req_rnd[g], req_mod[g]);
    end else if (out_ready) m_valid = 1'b0;
    if (iss) m_rr = (g + 1) % N;
  endtask

  // Runs one clock edge; always returns at a falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      req_operands[i][0] = $urandom;
      req_operands[i][1] = $urandom;
      req_op[i]    = 4'(32'(OpSgnj) + $urandom_range(0, 3));
      req_rnd[i]   = 3'($urandom_range(0, 4));
      req_mod[i]   = 1'($urandom);
      req_boxed[i] = 2'($urandom);
    end
  endtask

  task automatic do_reset();
    req_valid = '0; flush = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic set_nv_op();
    req_operands[0][0] = 32'h0000_0001;
    req_operands[0][1] = 32'h0;
    req_op[0] = OpCmp;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; req_valid = 2'b11; out_ready = 1'b1;
    rand_fields();
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (nv_count !== 16'h0) begin errors++; $display("FAIL rst_nv got=%h exp=0", nv_count); end
    checks++; if (out_cls !== 10'h200) begin errors++; $display("FAIL rst_cls got=%h exp=200", out_cls); end
    checks++; if ({out_id, out_result, out_status, out_ext, out_iscls} !== '0) begin
      errors++; $display("FAIL rst_fields got=%h/%h/%h/%b/%b exp=0", out_id, out_result, out_status, out_ext, out_iscls);
    end
    req_valid = '0;
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_round_robin();
    int exp_g[4] = '{0, 1, 0, 1};
    do_reset();
    rand_fields();
    req_valid = 2'b11; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== 2'(1 << exp_g[i])) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, req_ready, 2'(1 << exp_g[i])); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_id !== 1'(exp_g[i])) begin
        errors++; $display("FAIL rr_id[%0d] got=%b/%0d exp=1/%0d", i, out_valid, out_id, exp_g[i]);
      end
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_fmin();
    do_reset();
    rand_fields();
    req_operands[0][0] = 32'h3F80_0000;
    req_operands[0][1] = 32'h4000_0000;
    req_op[0] = OpMinmax; req_rnd[0] = 3'd0;
    req_valid = 2'b01; out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01 || unit_op !== OpMinmax) begin errors++; $display("FAIL fmin_issue got=%b/%h exp=01/7", req_ready, unit_op); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h3F80_0000 || out_id !== 1'b0) begin
      errors++; $display("FAIL fmin_result got=%b/%h/%0d exp=1/3f800000/0", out_valid, out_result, out_id);
    end
    req_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmin_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rand_fields();
    req_valid = 2'b11; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, req_ready); end
      checks++; if (out_valid !== 1'b1 || out_id !== 1'b0 || out_result !== m_out.res || out_status !== m_out.st) begin
        errors++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h/%h exp=1/0/%h/%h", i, out_valid, out_id, out_result, out_status, m_out.res, m_out.st);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_resume1 got=%b exp=10", req_ready); end
    tick();
    checks++; if (out_id !== 1'b1) begin errors++; $display("FAIL bp_id1 got=%0d exp=1", out_id); end
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_resume0 got=%b exp=01", req_ready); end
    tick();
    checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL bp_id0 got=%0d exp=0", out_id); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_nv_flush();
    do_reset();
    rand_fields();
    set_nv_op();
    req_valid = 2'b01; out_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (nv_count !== 16'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL nv_two got=%0d/%b exp=2/1", nv_count, out_valid); end
    flush = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL flush_block got=%b exp=00", req_ready); end
    tick();
    checks++; if (nv_count !== 16'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_nv got=%0d/%b exp=2/0", nv_count, out_valid); end
    flush = 1'b0; req_valid = '0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    rand_fields();
    set_nv_op();
    req_valid = 2'b01; out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    checks++; if (nv_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got=%h exp=fffe", nv_count); end
    tick(); tick();
    checks++; if (nv_count !== 16'hFFFF) begin errors++; $display("FAIL sat_max got=%h exp=ffff", nv_count); end
    tick();
    checks++; if (nv_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", nv_count); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rand_fields();
    req_valid = 2'b01; out_ready = 1'b0;
    tick();
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b/%b exp=0/0", out_valid, busy); end
    checks++; if (req_ready !== 2'b00 || out_cls !== 10'h200 || out_id !== 1'b0) begin
      errors++; $display("FAIL midrst_state got=%b/%h/%0d exp=00/200/0", req_ready, out_cls, out_id);
    end
    #1 rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_grant got=%b exp=01", req_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_id !== 1'b0) begin errors++; $display("FAIL midrst_id got=%b/%0d exp=1/0", out_valid, out_id); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_random();
    int sel;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rand_fields();
      req_valid = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      sel = (grant_of() >= 0) ? grant_of() : m_rr;
      checks++; if (req_ready !== exp_ready()) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); end
      checks++; if (unit_op !== req_op[sel] || unit_operands !== req_operands[sel]) begin
        errors++; $display("FAIL rnd_unitmux c=%0d got=%h exp=%h", c, unit_op, req_op[sel]);
      end
      checks++; if (out_valid !== m_valid || busy !== m_valid) begin errors++; $display("FAIL rnd_valid c=%0d got=%b/%b exp=%b", c, out_valid, busy, m_valid); end
      checks++; if (nv_count !== 16'(m_nv)) begin errors++; $display("FAIL rnd_nv c=%0d got=%0d exp=%0d", c, nv_count, m_nv); end
      if (m_valid) begin
        checks++; if (out_id !== 1'(m_id) || {out_result, out_status, out_ext, out_cls, out_iscls} !== m_out) begin
          errors++; $display("FAIL rnd_out c=%0d got=%0d/%h exp=%0d/%h", c, out_id, {out_result, out_status, out_ext, out_cls, out_iscls}, m_id, m_out);
        end
      end
      tick();
    end
    req_valid = '0; flush = 1'b0;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_fmin();
    test_backpressure();
    test_nv_flush();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
